// File: rtl/pixel_writer_if.sv
// Pixel capture handshake, Avalon-MM write master bus and status signals of pixel_writer.
interface pixel_writer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             JW_done;
    logic [31:0]      color;
    logic [31:0]      address;
    logic             MC_done;
    logic [31:0]      avm_address;
    logic             avm_write;
    logic [31:0]      avm_writedata;
    logic [3:0]       avm_byteenable;
    logic             avm_waitrequest;
    logic [LVL_W-1:0] fifo_level;
    logic             frame_done;
    logic             idle;

    modport master (
        input  JW_done, color, address, avm_waitrequest,
        output MC_done, avm_address, avm_write, avm_writedata, avm_byteenable,
        output fifo_level, frame_done, idle
    );

    modport slave (
        output JW_done, color, address, avm_waitrequest,
        input  MC_done, avm_address, avm_write, avm_writedata, avm_byteenable,
        input  fifo_level, frame_done, idle
    );
endinterface

// File: rtl/pixel_writer.sv
// Queues worker pixels and drains them as single-word Avalon writes; MC_done 1 cycle after capture,
// avm_write 2 cycles after capture; a full FIFO stalls the worker, waitrequest holds the bus stable.
module pixel_writer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic          clk,
    input  logic          rst,
    pixel_writer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [63:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [0:0]       state_q, state_d;
    logic             avm_write_q, avm_write_d;
    logic [31:0]      avm_address_q, avm_address_d;
    logic [31:0]      avm_writedata_q, avm_writedata_d;
    logic             mc_done_q, mc_done_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             frame_done_q, frame_done_d;

    logic push;
    logic pop;
    logic accept;
    logic empty;

    always_comb begin
        empty  = (level_q == '0);
        // MC_done high blocks the held JW_done from being captured a second time.
        push   = bus.JW_done && !mc_done_q && (level_q != LVL_W'(FIFO_DEPTH));
        accept = (state_q == S_WRITE) && !bus.avm_waitrequest;
        pop    = !empty && ((state_q == S_IDLE) || accept);

        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        state_d         = state_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        mc_done_d       = 1'b0;
        frame_cnt_d     = frame_cnt_q;
        frame_done_d    = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.address, bus.color};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            mc_done_d       = 1'b1;
        end

        if (pop) begin
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            avm_address_d   = mem_q[rd_ptr_q][63:32];
            avm_writedata_d = mem_q[rd_ptr_q][31:0];
            avm_write_d     = 1'b1;
            state_d         = S_WRITE;
        end else if (accept) begin
            avm_write_d = 1'b0;
            state_d     = S_IDLE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (accept) begin
            if (frame_cnt_q == CNT_W'(FRAME_PIXELS - 1)) begin
                frame_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            state_q         <= S_IDLE;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            mc_done_q       <= 1'b0;
            frame_cnt_q     <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            state_q         <= state_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            mc_done_q       <= mc_done_d;
            frame_cnt_q     <= frame_cnt_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.MC_done        = mc_done_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign bus.avm_byteenable = 4'hF;
    assign bus.fifo_level     = level_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.idle           = (state_q == S_IDLE) && (level_q == '0);
endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: capture/write latency, back-pressure, wait-state hold, frame wrap, reset.
module tb_pixel_writer;
    logic clk;
    logic rst;

    pixel_writer_if #(.FIFO_DEPTH(8)) bus ();

    pixel_writer #(
        .FIFO_DEPTH  (8),
        .FRAME_PIXELS(4),
        .CNT_W       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    logic rand_wr = 1'b0;

    // Bus monitor state (written only by the monitor process)
    int          mc_cnt     = 0;
    int          acc_total  = 0;
    logic [63:0] acc_q[$];
    int          fd_q[$];
    logic        hold_prev  = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;
    int          hold_cnt   = 0;
    int          hold_err   = 0;
    logic        fd_prev    = 1'b0;
    int          fd_consec  = 0;

    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pix(input int i);
        logic [31:0] a;
        logic [31:0] c;
        a = 32'h0800_0000 + 32'(i) * 32'd4;
        c = 32'hC0DE_0000 + 32'(i);
        return {a, c};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
            fd_prev   = 1'b0;
        end else begin
            if (bus.MC_done) mc_cnt++;
            if (bus.frame_done) begin
                fd_q.push_back(acc_total);
                if (fd_prev) fd_consec++;
            end
            fd_prev = bus.frame_done;
            if (hold_prev && bus.avm_write) begin
                hold_cnt++;
                if (bus.avm_address !== prev_addr || bus.avm_writedata !== prev_data) hold_err++;
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                acc_q.push_back({bus.avm_address, bus.avm_writedata});
                acc_total++;
            end
            hold_prev = bus.avm_write && bus.avm_waitrequest;
            prev_addr = bus.avm_address;
            prev_data = bus.avm_writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wr) bus.avm_waitrequest = 1'($urandom_range(0, 1));
    endtask

    task automatic push_pixel(input int i, input int limit);
        logic [63:0] p;
        logic        ok;
        p = pix(i);
        bus.address = p[63:32];
        bus.color   = p[31:0];
        bus.JW_done = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (bus.MC_done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.JW_done = 1'b0;
        chk("push_ack", ok, 1);
    endtask

    task automatic wait_idle(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (bus.idle && !bus.avm_write) break;
            tick();
        end
        chk("reach_idle", bus.idle, 1);
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_count"}, acc_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < acc_q.size()) chk(tag, acc_q[base + i], exp_q[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mc_done"}, bus.MC_done, 0);
        chk({tag, "_avm_write"}, bus.avm_write, 0);
        chk({tag, "_avm_address"}, bus.avm_address, 0);
        chk({tag, "_avm_writedata"}, bus.avm_writedata, 0);
        chk({tag, "_byteenable"}, bus.avm_byteenable, 4'hF);
        chk({tag, "_fifo_level"}, bus.fifo_level, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_idle"}, bus.idle, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int mc_base;
        int fd_base;
        int tot_base;
        int consec;
        logic mc_prev;
        logic [63:0] p;

        rst = 1'b1;
        bus.JW_done = 1'b0;
        bus.address = '0;
        bus.color   = '0;
        bus.avm_waitrequest = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("por");

        // Single pixel: capture at cycle N, MC_done at N+1, write at N+2, drop at N+3
        base = acc_q.size();
        mc_base = mc_cnt;
        bus.address = 32'h0800_0000;
        bus.color   = 32'h00FF_00FF;
        bus.JW_done = 1'b1;
        tick();
        bus.JW_done = 1'b0;
        chk("single_mc_done", bus.MC_done, 1);
        chk("single_level1", bus.fifo_level, 1);
        chk("single_no_write_yet", bus.avm_write, 0);
        tick();
        chk("single_write", bus.avm_write, 1);
        chk("single_addr", bus.avm_address, 32'h0800_0000);
        chk("single_data", bus.avm_writedata, 32'h00FF_00FF);
        chk("single_mc_drop", bus.MC_done, 0);
        tick();
        chk("single_write_drop", bus.avm_write, 0);
        chk("single_idle", bus.idle, 1);
        repeat (3) tick();
        chk("single_mc_pulses", mc_cnt - mc_base, 1);
        exp_q.delete();
        exp_q.push_back({32'h0800_0000, 32'h00FF_00FF});
        check_writes("single_wr", base);

        // Back-pressure: one entry on the bus plus 8 queued, the 10th must stall
        bus.avm_waitrequest = 1'b1;
        base = acc_q.size();
        mc_base = mc_cnt;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            push_pixel(i, 6);
            exp_q.push_back(pix(i));
        end
        exp_q.push_back(pix(9));
        p = pix(9);
        bus.address = p[63:32];
        bus.color   = p[31:0];
        bus.JW_done = 1'b1;
        repeat (5) tick();
        chk("bp_mc_pulses", mc_cnt - mc_base, 9);
        chk("bp_stall_mc", bus.MC_done, 0);
        chk("bp_level_full", bus.fifo_level, 8);
        chk("bp_head_write", bus.avm_write, 1);
        p = pix(0);
        chk("bp_head_addr", bus.avm_address, p[63:32]);
        chk("bp_head_data", bus.avm_writedata, p[31:0]);
        bus.avm_waitrequest = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_no_bubble", bus.avm_write, 1);
            if (bus.MC_done) bus.JW_done = 1'b0;
            tick();
        end
        bus.JW_done = 1'b0;
        chk("bp_drained", bus.avm_write, 0);
        chk("bp_mc_total", mc_cnt - mc_base, 10);
        check_writes("bp_wr", base);

        // Random wait states
        base = acc_q.size();
        exp_q.delete();
        rand_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_pixel(100 + i, 20);
            exp_q.push_back(pix(100 + i));
        end
        repeat (4) tick();
        rand_wr = 1'b0;
        bus.avm_waitrequest = 1'b0;
        wait_idle(40);
        check_writes("ws_wr", base);

        // Held JW_done for 10 cycles: capture every other cycle
        base = acc_q.size();
        mc_base = mc_cnt;
        consec = 0;
        mc_prev = 1'b0;
        p = pix(40);
        bus.address = p[63:32];
        bus.color   = p[31:0];
        bus.JW_done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.MC_done && mc_prev) consec++;
            mc_prev = bus.MC_done;
        end
        bus.JW_done = 1'b0;
        wait_idle(40);
        chk("held_mc_pulses", mc_cnt - mc_base, 5);
        chk("held_no_consec", consec, 0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(pix(40));
        check_writes("held_wr", base);

        // Frame wrap with FRAME_PIXELS=4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fd_base  = fd_q.size();
        tot_base = acc_total;
        for (int i = 0; i < 8; i++) push_pixel(200 + i, 6);
        wait_idle(40);
        repeat (2) tick();
        chk("frame_pulses", fd_q.size() - fd_base, 2);
        if (fd_q.size() >= fd_base + 2) begin
            chk("frame_first", fd_q[fd_base] - tot_base, 4);
            chk("frame_second", fd_q[fd_base + 1] - tot_base, 8);
        end
        chk("frame_no_consec", fd_consec, 0);

        // Reset while a write is stalled with 3 entries queued
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) push_pixel(20 + i, 6);
        chk("mid_level3", bus.fifo_level, 3);
        chk("mid_write_active", bus.avm_write, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("mid");
        bus.avm_waitrequest = 1'b0;
        base = acc_q.size();
        repeat (4) tick();
        chk("mid_no_writes", acc_q.size() - base, 0);
        chk("mid_still_idle", bus.idle, 1);
        exp_q.delete();
        exp_q.push_back(pix(30));
        push_pixel(30, 6);
        wait_idle(20);
        check_writes("mid_after", base);

        chk("hold_checked", hold_cnt > 0, 1);
        chk("hold_stable", hold_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
